// File: rtl/add_serial_pkg.sv
// Shared types and defaults for the add_serial controller and its operand FIFO.
// The optional result tag is enabled by ADD_SERIAL_CTRL_TAG_EN in add_serial_ctrl.
package add_serial_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int ADD_LAT_DEF = 9;
  localparam int TAG_WIDTH   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD
  } state_e;

endpackage

// File: rtl/add_serial_fifo.sv
// Operand-pair FIFO: each entry packs {A, B}; one-extra-bit pointers give full/empty.
module add_serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic [2*WIDTH-1:0] wdata_i,
  input  logic               pop_i,
  output logic [2*WIDTH-1:0] rdata_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]          wr_ptr_q;
  logic [AW:0]          rd_ptr_q;
  logic [2*WIDTH-1:0]   mem_q [DEPTH];
  logic                 do_push;
  logic                 do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: stale entries are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/add_serial_ctrl.sv
// Operand sequencer and result collector for the add_serial bit-serial adder.
// Define ADD_SERIAL_CTRL_TAG_EN to add the res_tag port and its sequence counter.
module add_serial_ctrl
  import add_serial_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int DEPTH   = 4,
  parameter int ADD_LAT = ADD_LAT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 add_en,
  output logic [WIDTH-1:0]     add_a,
  output logic [WIDTH-1:0]     add_b,
  input  logic [WIDTH-1:0]     add_out,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [WIDTH-1:0]     res_data
`ifdef ADD_SERIAL_CTRL_TAG_EN
  ,
  output logic [TAG_WIDTH-1:0] res_tag
`endif
);

  localparam int LW = $clog2(ADD_LAT) + 1;
  localparam logic [LW-1:0] LAT_LAST = LW'(ADD_LAT - 1);

  state_e             state_q;
  logic [LW-1:0]      lat_cnt_q;
  logic [LW-1:0]      lat_cnt_d;
  logic               add_en_q;
  logic [WIDTH-1:0]   add_a_q;
  logic [WIDTH-1:0]   add_b_q;
  logic               res_valid_q;
  logic [WIDTH-1:0]   res_data_q;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [2*WIDTH-1:0] fifo_head;

  add_serial_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .wdata_i ({in_a, in_b}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready  = !fifo_full;
  assign fifo_pop  = (state_q == S_ISSUE);
  assign lat_cnt_d = lat_cnt_q + LW'(1);

  assign add_en    = add_en_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

`ifdef ADD_SERIAL_CTRL_TAG_EN
  logic [TAG_WIDTH-1:0] tag_q;
  assign res_tag = tag_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q <= '0;
    end else if (state_q == S_HOLD && res_ready) begin
      tag_q <= tag_q + TAG_WIDTH'(1);
    end
  end
`endif

  // Operands and the enable are loaded on the way into S_ISSUE so the pulse
  // and its operands are registered and coincide with the issue cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= '0;
      add_en_q    <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!fifo_empty) begin
            add_en_q <= 1'b1;
            add_a_q  <= fifo_head[2*WIDTH-1:WIDTH];
            add_b_q  <= fifo_head[WIDTH-1:0];
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          add_en_q  <= 1'b0;
          lat_cnt_q <= '0;
          state_q   <= S_WAIT;
        end
        S_WAIT: begin
          lat_cnt_q <= lat_cnt_d;
          if (lat_cnt_d == LAT_LAST) begin
            res_data_q  <= add_out;
            res_valid_q <= 1'b1;
            state_q     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_serial_ctrl.sv
// Randomized self-checking bench for add_serial_ctrl with a behavioural adder model.
// Tag checks are compiled in when ADD_SERIAL_CTRL_TAG_EN is defined.
module tb_add_serial_ctrl;

  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int ADD_LAT = 9;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } pair_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             add_en;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_out;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
`ifdef ADD_SERIAL_CTRL_TAG_EN
  logic [3:0]       res_tag;
`endif

  int checkCount = 0;
  int passCount  = 0;

  pair_t            pendQ[$];
  logic [WIDTH-1:0] resQ[$];
  int               expTag = 0;
  int               cyc = 0;
  int               lastEnCyc = -1;
  int               issueCyc = 0;
  logic             prevResValid = 1'b0;
  pair_t            monPair;
  logic [WIDTH-1:0] monSum;

  int               addCnt;
  logic [WIDTH-1:0] opSum;

  always #5 clk = ~clk;

  add_serial_ctrl #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .ADD_LAT (ADD_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_en    (add_en),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_out   (add_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data)
`ifdef ADD_SERIAL_CTRL_TAG_EN
    ,
    .res_tag   (res_tag)
`endif
  );

  task automatic checkOutput(input string tagName, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tagName, observed, expected);
  endtask

  // Adder stand-in: output is junk until the sum settles one cycle before capture.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      addCnt  <= 0;
      add_out <= '0;
    end else if (add_en) begin
      opSum   <= add_a + add_b;
      add_out <= ~(add_a + add_b);
      addCnt  <= 1;
    end else if (addCnt != 0 && addCnt < ADD_LAT) begin
      addCnt <= addCnt + 1;
      if (addCnt == ADD_LAT - 2) add_out <= opSum;
    end
  end

  // Transaction-level reference: accepted pairs queue up, each issue moves the
  // head's sum to the result queue, each accepted result must match in order.
  always @(negedge clk) begin
    if (rst) begin
      cyc++;
      if (add_en) begin
        if (pendQ.size() == 0) begin
          checkOutput("en_spurious", 1, 0);
        end else begin
          monPair = pendQ.pop_front();
          checkOutput("add_a", add_a, monPair.a);
          checkOutput("add_b", add_b, monPair.b);
          monSum = monPair.a + monPair.b;
          resQ.push_back(monSum);
        end
        if (lastEnCyc >= 0) checkOutput("en_gap_ok", (cyc - lastEnCyc) >= ADD_LAT + 2, 1);
        lastEnCyc = cyc;
        issueCyc  = cyc;
      end
      if (res_valid && !prevResValid) checkOutput("res_latency", cyc - issueCyc, ADD_LAT);
      if (res_valid && res_ready) begin
        if (resQ.size() == 0) begin
          checkOutput("res_spurious", 1, 0);
        end else begin
          checkOutput("res_data", res_data, resQ.pop_front());
        end
`ifdef ADD_SERIAL_CTRL_TAG_EN
        checkOutput("res_tag", res_tag, expTag);
`endif
        expTag = (expTag + 1) % 16;
      end
      if (in_valid && in_ready) pendQ.push_back(pair_t'({in_a, in_b}));
      prevResValid = res_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    in_valid = v;
    in_a     = a;
    in_b     = b;
  endtask

  task automatic pushPair(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    applyStimulus(1'b1, a, b);
    tick();
    applyStimulus(1'b0, '0, '0);
  endtask

  task automatic waitEn(output int n);
    n = 0;
    while (!add_en && n < 100) begin
      tick();
      n++;
    end
    if (!add_en) checkOutput("timeout_en", 0, 1);
  endtask

  task automatic waitRes(output int n);
    n = 0;
    while (!res_valid && n < 100) begin
      tick();
      n++;
    end
    if (!res_valid) checkOutput("timeout_res", 0, 1);
  endtask

  task automatic drain();
    int n;
    res_ready = 1'b1;
    n = 0;
    while ((resQ.size() != 0 || pendQ.size() != 0 || res_valid) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) checkOutput("timeout_drain", 0, 1);
  endtask

  task automatic runOp(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [WIDTH-1:0] expSum);
    int n;
    pushPair(a, b);
    waitEn(n);
    waitRes(n);
    checkOutput(name, res_data, expSum);
    tick();
  endtask

  task automatic clearModel();
    pendQ.delete();
    resQ.delete();
    expTag       = 0;
    lastEnCyc    = -1;
    prevResValid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int accepted;
    int enSeen;
    int validSeen;
    logic stable;
    logic [WIDTH-1:0] held;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] rs;

    rst = 1'b0;
    res_ready = 1'b0;
    applyStimulus(1'b0, '0, '0);
    #12;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_add_en", add_en, 0);
    checkOutput("rst_add_a", add_a, 0);
    checkOutput("rst_add_b", add_b, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_res_data", res_data, 0);
`ifdef ADD_SERIAL_CTRL_TAG_EN
    checkOutput("rst_res_tag", res_tag, 0);
`endif
    tick();
    rst = 1'b1;
    tick();

    res_ready = 1'b1;
    pushPair(8'h12, 8'h34);
    waitEn(n);
    checkOutput("push_to_en", n + 1, 2);
    waitRes(n);
    checkOutput("en_to_valid", n, ADD_LAT);
    checkOutput("single_sum", res_data, 8'h46);
`ifdef ADD_SERIAL_CTRL_TAG_EN
    checkOutput("single_tag", res_tag, 0);
`endif
    tick();

    runOp("wrap_ff_01", 8'hFF, 8'h01, 8'h00);
    runOp("wrap_80_80", 8'h80, 8'h80, 8'h00);

    res_ready = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom));
      if (i == 5) checkOutput("in_ready_6th", in_ready, 0);
      if (in_ready) accepted++;
      tick();
    end
    applyStimulus(1'b0, '0, '0);
    checkOutput("fifo_accepted", accepted, 5);

    waitRes(n);
    held = res_data;
    stable = 1'b1;
    enSeen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (add_en) enSeen++;
      if (res_data !== held) stable = 1'b0;
    end
    checkOutput("hold_stable", stable, 1);
    checkOutput("hold_no_issue", enSeen, 0);
    checkOutput("hold_valid", res_valid, 1);
    checkOutput("hold_full", in_ready, 0);
    drain();

    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom));
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    applyStimulus(1'b0, '0, '0);
    drain();

    pushPair(8'h5A, 8'h3C);
    pushPair(8'h11, 8'h22);
    waitEn(n);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_add_en", add_en, 0);
    checkOutput("mid_rst_add_a", add_a, 0);
    checkOutput("mid_rst_add_b", add_b, 0);
    checkOutput("mid_rst_res_valid", res_valid, 0);
    checkOutput("mid_rst_res_data", res_data, 0);
    checkOutput("mid_rst_in_ready", in_ready, 1);
`ifdef ADD_SERIAL_CTRL_TAG_EN
    checkOutput("mid_rst_res_tag", res_tag, 0);
`endif
    clearModel();
    tick();
    tick();
    rst = 1'b1;
    validSeen = 0;
    enSeen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (res_valid) validSeen++;
      if (add_en) enSeen++;
    end
    checkOutput("post_rst_no_valid", validSeen, 0);
    checkOutput("post_rst_no_issue", enSeen, 0);
    checkOutput("post_rst_in_ready", in_ready, 1);

    res_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      rs = ra + rb;
      pushPair(ra, rb);
      waitEn(n);
      waitRes(n);
      checkOutput("seq_sum", res_data, rs);
`ifdef ADD_SERIAL_CTRL_TAG_EN
      checkOutput("seq_tag", res_tag, i % 16);
`endif
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
